// File: rtl/decoder_scan_nx_pkg.sv
// Shared definitions for the scanning one-hot select decoder.
package decoder_scan_nx_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_COUNT,
    ACT_STEP
  } idx_action_e;

endpackage

// File: rtl/decoder_scan_nx_onehot_dec.sv
// Generic combinational N-to-2^N one-hot decoder with enable.
module onehot_dec #(
  parameter int N_SEL = 2
) (
  input  logic                  en_i,
  input  logic [N_SEL-1:0]      sel_i,
  output logic [(2**N_SEL)-1:0] oh_o
);

  localparam int OUT_W = 2**N_SEL;

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o = OUT_W'(1) << sel_i;
  end

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered one-hot select decoder: DIRECT decodes din, SCAN steps an index 0..last.
module decoder_scan_nx
  import decoder_scan_nx_pkg::*;
#(
  parameter int N_SEL      = 2,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [N_SEL-1:0]      din,
  input  logic [DIV_W-1:0]      div,
  input  logic [N_SEL-1:0]      last,
  output logic [(2**N_SEL)-1:0] dout,
  output logic [N_SEL-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**N_SEL;
  localparam logic [OUT_W-1:0] DOUT_IDLE = {OUT_W{ACTIVE_LOW}};

  logic [N_SEL-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic [OUT_W-1:0] oh;
  idx_action_e      act;

  always_comb begin
    act = ACT_HOLD;
    if (en) begin
      if (mode == MODE_DIRECT)  act = ACT_LOAD;
      else if (presc_q >= div)  act = ACT_STEP;  // >= so a lowered div steps at once
      else                      act = ACT_COUNT;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    unique case (act)
      ACT_HOLD:  ;
      ACT_LOAD: begin
        idx_d   = din;
        presc_d = '0;
      end
      ACT_COUNT: presc_d = presc_q + DIV_W'(1);
      ACT_STEP: begin
        presc_d = '0;
        if (idx_q >= last) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + N_SEL'(1);
        end
      end
      default: ;
    endcase
  end

  onehot_dec #(.N_SEL(N_SEL)) u_dec (
    .en_i  (en),
    .sel_i (idx_d),
    .oh_o  (oh)
  );

  always_comb begin
    dout_d = ACTIVE_LOW ? ~oh : oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      dout_q  <= DOUT_IDLE;
    end else begin
      idx_q   <= idx_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Randomised and directed bench for decoder_scan_nx (N_SEL=2 and N_SEL=3 active-low builds).
module tb_decoder_scan_nx;

  logic        clk, rst, en, mode;
  logic [1:0]  din, last;
  logic [2:0]  din3, last3;
  logic [15:0] div;
  logic [3:0]  dout;
  logic [1:0]  idx;
  logic        wrap;
  logic [7:0]  dout3;
  logic [2:0]  idx3;
  logic        wrap3;

  int checks = 0;
  int errors = 0;

  decoder_scan_nx #(.N_SEL(2), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .div(div),
    .last(last), .dout(dout), .idx(idx), .wrap(wrap)
  );

  decoder_scan_nx #(.N_SEL(3), .DIV_W(16), .ACTIVE_LOW(1'b1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din3), .div(div),
    .last(last3), .dout(dout3), .idx(idx3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the N_SEL=2 instance, written from the behavioural rules.
  logic [1:0]  m_idx;
  logic [15:0] m_presc;
  logic        m_wrap, m_on;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx <= 2'd0; m_presc <= 16'd0; m_wrap <= 1'b0; m_on <= 1'b0;
    end else if (!en) begin
      m_wrap <= 1'b0; m_on <= 1'b0;
    end else if (mode == 1'b0) begin
      m_idx <= din; m_presc <= 16'd0; m_wrap <= 1'b0; m_on <= 1'b1;
    end else begin
      m_on <= 1'b1;
      if (m_presc >= div) begin
        m_presc <= 16'd0;
        m_wrap  <= (m_idx >= last);
        m_idx   <= (m_idx >= last) ? 2'd0 : m_idx + 2'd1;
      end else begin
        m_presc <= m_presc + 16'd1;
        m_wrap  <= 1'b0;
      end
    end
  end

  function automatic logic [3:0] oh4(input int i);
    return 4'(1 << i);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; din = '0; din3 = '0;
    div = '0; last = 2'd3; last3 = 3'd7;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp_v;
    do_reset();
    checks++;
    if ({dout, idx, wrap} !== 7'b0) begin
      errors++; $display("FAIL reset_init got %b exp %b", {dout, idx, wrap}, 7'b0);
    end
    checks++;
    if (dout3 !== 8'hFF) begin
      errors++; $display("FAIL reset_init_al got %h exp %h", dout3, 8'hFF);
    end
    en = 1'b1; mode = 1'b1; div = 16'd0; last = 2'd3;
    step(); step();
    exp_v = {oh4(2), 2'd2, 1'b0};
    checks++;
    if ({dout, idx, wrap} !== exp_v) begin
      errors++; $display("FAIL reset_prerun got %b exp %b", {dout, idx, wrap}, exp_v);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({dout, idx, wrap} !== 7'b0) begin
      errors++; $display("FAIL reset_async got %b exp %b", {dout, idx, wrap}, 7'b0);
    end
    checks++;
    if ({dout3, idx3, wrap3} !== {8'hFF, 3'd0, 1'b0}) begin
      errors++; $display("FAIL reset_async_al got %h/%0d/%b exp ff/0/0", dout3, idx3, wrap3);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    en = 1'b1; mode = 1'b0; div = 16'd7; last = 2'd1;
    for (int k = 0; k < 4; k++) begin
      din = 2'(k);
      step();
      checks++;
      if ({dout, idx, wrap} !== {oh4(k), 2'(k), 1'b0}) begin
        errors++; $display("FAIL direct_%0d got %b exp %b", k, {dout, idx, wrap}, {oh4(k), 2'(k), 1'b0});
      end
    end
    en = 1'b0; din = 2'd1;
    step();
    checks++;
    if ({dout, idx, wrap} !== {4'b0000, 2'd3, 1'b0}) begin
      errors++; $display("FAIL direct_disable got %b exp %b", {dout, idx, wrap}, {4'b0000, 2'd3, 1'b0});
    end
  endtask

  task automatic test_scan();
    int e_idx, wraps;
    do_reset();
    en = 1'b1; mode = 1'b1; div = 16'd2; last = 2'd3;
    wraps = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      e_idx = (k / 3) % 4;
      wraps += int'(wrap);
      checks++;
      if ({dout, idx, wrap} !== {oh4(e_idx), 2'(e_idx), (k == 12)}) begin
        errors++; $display("FAIL scan_div2 k=%0d got %b exp %b", k, {dout, idx, wrap}, {oh4(e_idx), 2'(e_idx), (k == 12)});
      end
    end
    checks++;
    if (wraps !== 1) begin
      errors++; $display("FAIL scan_wrap_count got %0d exp 1", wraps);
    end
  endtask

  task automatic test_fast_scan();
    do_reset();
    en = 1'b1; mode = 1'b1; div = 16'd0; last = 2'd1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if ({idx, wrap} !== {2'(k % 2), (k % 2 == 0)}) begin
        errors++; $display("FAIL scan_div0 k=%0d got %b exp %b", k, {idx, wrap}, {2'(k % 2), (k % 2 == 0)});
      end
    end
    last = 2'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({dout, idx, wrap} !== {4'b0001, 2'd0, 1'b1}) begin
        errors++; $display("FAIL scan_last0 k=%0d got %b exp %b", k, {dout, idx, wrap}, {4'b0001, 2'd0, 1'b1});
      end
    end
  endtask

  task automatic test_pause();
    int ecnt, e_idx;
    do_reset();
    en = 1'b1; mode = 1'b1; div = 16'd4; last = 2'd3;
    ecnt = 0;
    for (int k = 0; k < 2; k++) begin step(); ecnt++; end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({dout, idx, wrap} !== {4'b0000, 2'd0, 1'b0}) begin
        errors++; $display("FAIL pause k=%0d got %b exp %b", k, {dout, idx, wrap}, 7'b0);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(); ecnt++;
      e_idx = (ecnt / 5) % 4;
      checks++;
      if ({dout, idx, wrap} !== {oh4(e_idx), 2'(e_idx), 1'b0}) begin
        errors++; $display("FAIL resume e=%0d got %b exp %b", ecnt, {dout, idx, wrap}, {oh4(e_idx), 2'(e_idx), 1'b0});
      end
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    en = 1'b1; mode = 1'b1; div = 16'd1; last = 2'd3; last3 = 3'd7;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (idx !== 2'd2) begin
      errors++; $display("FAIL switch_pre got %0d exp 2", idx);
    end
    mode = 1'b0; din = 2'd1; din3 = 3'd5;
    step();
    checks++;
    if ({dout, idx} !== {4'b0010, 2'd1}) begin
      errors++; $display("FAIL switch_direct got %b exp %b", {dout, idx}, {4'b0010, 2'd1});
    end
    checks++;
    if ({dout3, idx3} !== {8'hDF, 3'd5}) begin
      errors++; $display("FAIL switch_direct_n3 got %h/%0d exp df/5", dout3, idx3);
    end
    mode = 1'b1;
    step();
    checks++;
    if ({dout, idx} !== {4'b0010, 2'd1}) begin
      errors++; $display("FAIL switch_scan_hold got %b exp %b", {dout, idx}, {4'b0010, 2'd1});
    end
    step();
    checks++;
    if ({dout, idx} !== {4'b0100, 2'd2}) begin
      errors++; $display("FAIL switch_scan_step got %b exp %b", {dout, idx}, {4'b0100, 2'd2});
    end
    checks++;
    if ({dout3, idx3} !== {8'hBF, 3'd6}) begin
      errors++; $display("FAIL switch_scan_n3 got %h/%0d exp bf/6", dout3, idx3);
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_v;
    do_reset();
    en = 1'b1; mode = 1'b1; div = 16'd3; last = 2'd3;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      din = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) last = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) div = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
      exp_v = {m_on ? oh4(int'(m_idx)) : 4'b0000, m_idx, m_wrap};
      checks++;
      if ({dout, idx, wrap} !== exp_v) begin
        errors++; $display("FAIL random k=%0d got %b exp %b", k, {dout, idx, wrap}, exp_v);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; din = '0; din3 = '0;
    div = '0; last = '0; last3 = '0;
    test_reset();
    test_direct();
    test_scan();
    test_fast_scan();
    test_pause();
    test_mode_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
